// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap/MRET sequencer issuing a one-cycle fetch redirect.
// Optional feature: define TCORE_MTVEC_VECTORED_EN for mtvec vectored interrupt mode.
module trap_csr_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] MISA_VALUE  = XLEN'(32'h4000_1104)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            trap_active_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_mepc_i,
    input  logic            mret_i,
    input  logic            instr_ret_i,
    input  logic            csr_en_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            mie_o
);

    localparam int unsigned CNT_W = 2 * XLEN;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] LSB_CLEAR     = ~XLEN'(1);

`ifdef TCORE_MTVEC_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(2);
`else
    localparam logic [XLEN-1:0] MTVEC_WMASK = ~XLEN'(3);
`endif

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e             state_q;
    logic               redirect_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic               mie_q, mie_d;
    logic               mpie_q, mpie_d;
    logic [XLEN-1:0]    mtvec_q, mtvec_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    mscratch_q, mscratch_d;
    logic [CNT_W-1:0]   mcycle_q, mcycle_d;
    logic [CNT_W-1:0]   minstret_q, minstret_d;

    logic [XLEN-1:0]    rdata_c;
    logic               addr_ok_c;
    logic               is_write_c;
    logic [XLEN-1:0]    wval_c;
    logic [XLEN-1:0]    mtvec_base_c;
    logic [XLEN-1:0]    trap_pc_c;
    logic               run_go_c;
    logic               trap_take_c;
    logic               mret_take_c;
    logic               csr_we_c;

    // CSR read mux; unknown addresses read zero and flag illegal
    always_comb begin
        rdata_c   = '0;
        addr_ok_c = 1'b1;
        case (csr_addr_i)
            A_MSTATUS: begin
                rdata_c    = MSTATUS_FIXED;
                rdata_c[7] = mpie_q;
                rdata_c[3] = mie_q;
            end
            A_MISA:       rdata_c = MISA_VALUE;
            A_MTVEC:      rdata_c = mtvec_q;
            A_MSCRATCH:   rdata_c = mscratch_q;
            A_MEPC:       rdata_c = mepc_q;
            A_MCAUSE:     rdata_c = mcause_q;
            A_MCYCLE:     rdata_c = mcycle_q[XLEN-1:0];
            A_MCYCLEH:    rdata_c = mcycle_q[CNT_W-1:XLEN];
            A_MINSTRET:   rdata_c = minstret_q[XLEN-1:0];
            A_MINSTRETH:  rdata_c = minstret_q[CNT_W-1:XLEN];
            A_MHARTID:    rdata_c = '0;
            default:      addr_ok_c = 1'b0;
        endcase
    end

    assign is_write_c = (csr_op_i == OP_RW) ||
                        (((csr_op_i == OP_RS) || (csr_op_i == OP_RC)) && (csr_wdata_i != '0));

    assign csr_rdata_o   = rdata_c;
    assign csr_illegal_o = csr_en_i && (!addr_ok_c || (is_write_c && (csr_addr_i[11:10] == 2'b11)));

    always_comb begin
        case (csr_op_i)
            OP_RW:   wval_c = csr_wdata_i;
            OP_RS:   wval_c = rdata_c | csr_wdata_i;
            OP_RC:   wval_c = rdata_c & ~csr_wdata_i;
            default: wval_c = rdata_c;
        endcase
    end

    assign mtvec_base_c = {mtvec_q[XLEN-1:2], 2'b00};
    assign mtvec_o      = mtvec_base_c;

    // Interrupts in vectored mode jump to base + 4*cause; exceptions use the base
`ifdef TCORE_MTVEC_VECTORED_EN
    assign trap_pc_c = (mtvec_q[0] && trap_cause_i[XLEN-1])
                     ? mtvec_base_c + (XLEN'(trap_cause_i[XLEN-2:0]) << 2)
                     : mtvec_base_c;
`else
    assign trap_pc_c = mtvec_base_c;
`endif

    assign run_go_c    = (state_q == ST_RUN) && !stall_i;
    assign trap_take_c = run_go_c && trap_active_i;
    assign mret_take_c = run_go_c && mret_i && !trap_active_i;
    assign csr_we_c    = run_go_c && csr_en_i && !csr_illegal_o && is_write_c &&
                         !trap_active_i && !mret_i;

    // CSR next-state: trap > mret > CSR write; counter writes override the increment
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mcycle_d   = mcycle_q + CNT_W'(1);
        minstret_d = minstret_q + CNT_W'(instr_ret_i && !stall_i);
        if (trap_take_c) begin
            mepc_d   = trap_mepc_i & LSB_CLEAR;
            mcause_d = trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take_c) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we_c) begin
            case (csr_addr_i)
                A_MSTATUS: begin
                    mie_d  = wval_c[3];
                    mpie_d = wval_c[7];
                end
                A_MTVEC:      mtvec_d = wval_c & MTVEC_WMASK;
                A_MSCRATCH:   mscratch_d = wval_c;
                A_MEPC:       mepc_d = wval_c & LSB_CLEAR;
                A_MCAUSE:     mcause_d = wval_c;
                A_MCYCLE:     mcycle_d[XLEN-1:0] = wval_c;
                A_MCYCLEH:    mcycle_d[CNT_W-1:XLEN] = wval_c;
                A_MINSTRET:   minstret_d[XLEN-1:0] = wval_c;
                A_MINSTRETH:  minstret_d[CNT_W-1:XLEN] = wval_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & MTVEC_WMASK;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Sequencer: a taken trap/mret redirects for one cycle while the pipeline flushes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (trap_take_c || mret_take_c) begin
                        state_q       <= ST_FLUSH;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= trap_take_c ? trap_pc_c : mepc_q;
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign mie_o         = mie_q;

endmodule
